// File: rtl/instr_fetch_pkg.sv
// Shared opcode constants, fetch FSM encoding and bubble helpers for instr_fetch.
package instr_fetch_pkg;

  localparam int unsigned OPC_W   = 4;
  localparam int unsigned INSTR_W = 16;
  localparam int unsigned CNT_W   = 8;

  // 4-bit major opcodes (InstrData[15:12])
  localparam logic [OPC_W-1:0] InsAdd = 4'b0000;
  localparam logic [OPC_W-1:0] InsSub = 4'b0001;
  localparam logic [OPC_W-1:0] InsAnd = 4'b0010;
  localparam logic [OPC_W-1:0] InsOr  = 4'b0011;
  localparam logic [OPC_W-1:0] InsXor = 4'b0100;
  localparam logic [OPC_W-1:0] InsNot = 4'b0101;
  localparam logic [OPC_W-1:0] InsSll = 4'b0110;
  localparam logic [OPC_W-1:0] InsSrl = 4'b0111;
  localparam logic [OPC_W-1:0] InsLw  = 4'b1000;
  localparam logic [OPC_W-1:0] InsSw  = 4'b1001;
  localparam logic [OPC_W-1:0] InsLi  = 4'b1010;
  localparam logic [OPC_W-1:0] InsJ   = 4'b1011;
  localparam logic [OPC_W-1:0] InsBEZ = 4'b1100;

  // Word loaded into IF/ID for a flushed or bubbled slot
  localparam logic [INSTR_W-1:0] NopWord = 16'h0000;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } fetchState_t;

  // Saturating +1 for the bubble counter
  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] cnt);
    return (cnt == 8'hFF) ? cnt : cnt + CNT_W'(1);
  endfunction

endpackage

// File: rtl/fetch_predecode.sv
// Flags control-transfer opcodes (J, BEZ) directly off the fetched word.
module fetch_predecode
  import instr_fetch_pkg::*;
(
  input  logic [3:0] Opcode,
  output logic       IsCtrl
);

  // Pure opcode compare, no state
  assign IsCtrl = (Opcode == InsJ) || (Opcode == InsBEZ);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, IF/ID register and branch-wait FSM.
// FETCH_PREDECODE_EN: when defined, J/BEZ are pre-decoded and fetch parks
// in WAIT until Redirect or Release; otherwise fetch streams straight on
// and only Redirect flushes.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W = 12,
  parameter logic [ADDR_W-1:0] RST_PC = '0
) (
  input  logic              Clk,
  input  logic              Rst,
  output logic [ADDR_W-1:0] InstrAddr,
  input  logic [15:0]       InstrData,
  input  logic              Stall,
  input  logic              Redirect,
  input  logic [ADDR_W-1:0] RedirectAddr,
  input  logic              Release,
  output logic [15:0]       IfIdInstr,
  output logic [ADDR_W-1:0] IfIdPC,
  output logic              IfIdValid,
  output logic              Waiting,
  output logic [7:0]        BubbleCnt
);

  logic [ADDR_W-1:0] pc;
  fetchState_t       state;
  logic              isCtrl;

  fetch_predecode uPredecode (
    .Opcode (InstrData[15:12]),
    .IsCtrl (isCtrl)
  );

`ifndef FETCH_PREDECODE_EN
  // Pre-decode result has no consumer when the wait feature is compiled out
  logic unusedIsCtrl;
  assign unusedIsCtrl = isCtrl;
`endif

  assign InstrAddr = pc;

  // PC, IF/ID register, wait FSM and bubble counter; Rst > Redirect > Stall > Release > fetch
  always_ff @(posedge Clk) begin
    if (Rst) begin
      pc        <= RST_PC;
      state     <= RUN;
      Waiting   <= 1'b0;
      IfIdInstr <= NopWord;
      IfIdPC    <= '0;
      IfIdValid <= 1'b0;
      BubbleCnt <= '0;
    end else if (Redirect) begin
      pc        <= RedirectAddr;
      state     <= RUN;
      Waiting   <= 1'b0;
      IfIdInstr <= NopWord;
      IfIdValid <= 1'b0;
      BubbleCnt <= satInc(BubbleCnt);
    end else if (Stall) begin
      // hold everything for the downstream hazard
    end else begin
      case (state)
        RUN: begin
          IfIdInstr <= InstrData;
          IfIdPC    <= pc;
          IfIdValid <= 1'b1;
          pc        <= pc + ADDR_W'(1);
`ifdef FETCH_PREDECODE_EN
          if (isCtrl) begin
            state   <= WAIT;
            Waiting <= 1'b1;
          end
`endif
        end
        WAIT: begin
          // PC already points past the branch; emit a bubble until resolved
          IfIdInstr <= NopWord;
          IfIdValid <= 1'b0;
          BubbleCnt <= satInc(BubbleCnt);
          if (Release) begin
            state   <= RUN;
            Waiting <= 1'b0;
          end
        end
        default: begin
          state   <= RUN;
          Waiting <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch (works with or without FETCH_PREDECODE_EN).
module tb_instr_fetch;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [11:0] InstrAddr;
  logic [15:0] InstrData;
  logic        Stall;
  logic        Redirect;
  logic [11:0] RedirectAddr;
  logic        Release;
  logic [15:0] IfIdInstr;
  logic [11:0] IfIdPC;
  logic        IfIdValid;
  logic        Waiting;
  logic [7:0]  BubbleCnt;

  logic [15:0] mem [0:4095];
  int passCnt  = 0;
  int failCnt  = 0;
  int totalCnt = 0;

  assign InstrData = mem[InstrAddr];

  always #5 Clk = ~Clk;

  instr_fetch dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .InstrAddr    (InstrAddr),
    .InstrData    (InstrData),
    .Stall        (Stall),
    .Redirect     (Redirect),
    .RedirectAddr (RedirectAddr),
    .Release      (Release),
    .IfIdInstr    (IfIdInstr),
    .IfIdPC       (IfIdPC),
    .IfIdValid    (IfIdValid),
    .Waiting      (Waiting),
    .BubbleCnt    (BubbleCnt)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCnt = totalCnt + 1;
    assert (obs === exp) passCnt = passCnt + 1;
    else begin
      failCnt = failCnt + 1;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic doReset();
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
  endtask

  task automatic chkValid(input string tag, input logic [11:0] pcExp);
    chk({tag, "_pc"}, 32'(IfIdPC), 32'(pcExp));
    chk({tag, "_valid"}, 32'(IfIdValid), 32'd1);
  endtask

  task automatic fillAdd();
    for (int i = 0; i < 4096; i++) mem[i] = {4'h0, 12'(i)};
  endtask

  initial begin
    Rst = 1'b1; Stall = 1'b0; Redirect = 1'b0; RedirectAddr = '0; Release = 1'b0;
    fillAdd();

    // Reset state
    doReset();
    chk("rst_valid", 32'(IfIdValid), 32'd0);
    chk("rst_pc",    32'(IfIdPC),    32'd0);
    chk("rst_instr", 32'(IfIdInstr), 32'h0000);
    chk("rst_cnt",   32'(BubbleCnt), 32'd0);
    chk("rst_wait",  32'(Waiting),   32'd0);
    chk("rst_addr",  32'(InstrAddr), 32'd0);

    // Straight-line fetch 0..3
    for (int k = 0; k < 4; k++) begin
      tick();
      chkValid($sformatf("seq%0d", k), 12'(k));
      chk($sformatf("seq%0d_instr", k), 32'(IfIdInstr), 32'(k));
    end

    // J at address 2
    mem[2] = 16'hB005;
    doReset();
    tick(); chkValid("j_a0", 12'd0);
    tick(); chkValid("j_a1", 12'd1);
    tick(); chkValid("j_a2", 12'd2);
    chk("j_instr", 32'(IfIdInstr), 32'hB005);
`ifdef FETCH_PREDECODE_EN
    chk("j_wait", 32'(Waiting), 32'd1);
    tick();
    chk("j_b1_valid", 32'(IfIdValid), 32'd0);
    chk("j_b1_cnt", 32'(BubbleCnt), 32'd1);
    chk("j_b1_addr", 32'(InstrAddr), 32'd3);
    tick();
    chk("j_b2_valid", 32'(IfIdValid), 32'd0);
    chk("j_b2_cnt", 32'(BubbleCnt), 32'd2);
    Redirect = 1'b1; RedirectAddr = 12'd5;
    tick();
    Redirect = 1'b0;
    chk("j_rd_valid", 32'(IfIdValid), 32'd0);
    chk("j_rd_cnt", 32'(BubbleCnt), 32'd3);
    chk("j_rd_wait", 32'(Waiting), 32'd0);
    tick(); chkValid("j_tgt", 12'd5);
    chk("j_tgt_cnt", 32'(BubbleCnt), 32'd3);
`else
    chk("j_nowait", 32'(Waiting), 32'd0);
    Release = 1'b1;
    tick(); chkValid("j_a3", 12'd3);
    Release = 1'b0;
    tick(); chkValid("j_a4", 12'd4);
    Redirect = 1'b1; RedirectAddr = 12'd5;
    tick();
    Redirect = 1'b0;
    chk("j_rd_valid", 32'(IfIdValid), 32'd0);
    chk("j_rd_cnt", 32'(BubbleCnt), 32'd1);
    tick(); chkValid("j_tgt", 12'd5);
    chk("j_tgt_cnt", 32'(BubbleCnt), 32'd1);
`endif
    mem[2] = 16'h0002;

    // BEZ at address 4 with Release
    mem[4] = 16'hC010;
    doReset();
    repeat (5) tick();
    chkValid("bez_a4", 12'd4);
`ifdef FETCH_PREDECODE_EN
    chk("bez_wait", 32'(Waiting), 32'd1);
    tick(); tick();
    chk("bez_b2_valid", 32'(IfIdValid), 32'd0);
    chk("bez_b2_cnt", 32'(BubbleCnt), 32'd2);
    Release = 1'b1;
    tick();
    Release = 1'b0;
    chk("bez_rel_wait", 32'(Waiting), 32'd0);
    chk("bez_rel_valid", 32'(IfIdValid), 32'd0);
    chk("bez_rel_cnt", 32'(BubbleCnt), 32'd3);
    tick(); chkValid("bez_a5", 12'd5);
    // Release while running is ignored
    Release = 1'b1;
    tick(); chkValid("bez_a6", 12'd6);
    Release = 1'b0;
    chk("bez_a6_wait", 32'(Waiting), 32'd0);
`else
    Release = 1'b1;
    tick(); chkValid("bez_a5", 12'd5);
    Release = 1'b0;
    chk("bez_a5_wait", 32'(Waiting), 32'd0);
    chk("bez_a5_cnt", 32'(BubbleCnt), 32'd0);
`endif
    mem[4] = 16'h0004;

    // Stall for 3 cycles with PC=7
    doReset();
    repeat (7) tick();
    chk("st_addr0", 32'(InstrAddr), 32'd7);
    Stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chkValid($sformatf("st%0d", k), 12'd6);
      chk($sformatf("st%0d_instr", k), 32'(IfIdInstr), 32'h0006);
      chk($sformatf("st%0d_addr", k), 32'(InstrAddr), 32'd7);
    end
    Stall = 1'b0;
    tick(); chkValid("st_resume", 12'd7);

    // Stall + Redirect: Redirect wins
    Stall = 1'b1; Redirect = 1'b1; RedirectAddr = 12'h0A0;
    tick();
    Stall = 1'b0; Redirect = 1'b0;
    chk("sr_valid", 32'(IfIdValid), 32'd0);
    chk("sr_addr", 32'(InstrAddr), 32'h0A0);
    chk("sr_cnt", 32'(BubbleCnt), 32'd1);
    tick(); chkValid("sr_tgt", 12'h0A0);

    // PC wrap at 0xFFF, then Rst coincident with Redirect
    mem[12'hFFF] = 16'hB000;
    Redirect = 1'b1; RedirectAddr = 12'hFFF;
    tick();
    Redirect = 1'b0;
    tick(); chkValid("wr_fff", 12'hFFF);
    chk("wr_addr", 32'(InstrAddr), 32'd0);
`ifdef FETCH_PREDECODE_EN
    chk("wr_wait", 32'(Waiting), 32'd1);
`endif
    Rst = 1'b1; Redirect = 1'b1; RedirectAddr = 12'h123;
    tick();
    Rst = 1'b0; Redirect = 1'b0;
    chk("rr_addr",  32'(InstrAddr), 32'd0);
    chk("rr_wait",  32'(Waiting),   32'd0);
    chk("rr_valid", 32'(IfIdValid), 32'd0);
    chk("rr_pc",    32'(IfIdPC),    32'd0);
    chk("rr_instr", 32'(IfIdInstr), 32'h0000);
    chk("rr_cnt",   32'(BubbleCnt), 32'd0);

    // 300 back-to-back Redirects saturate the bubble counter
    Redirect = 1'b1; RedirectAddr = 12'h100;
    repeat (254) tick();
    chk("sat_fe", 32'(BubbleCnt), 32'hFE);
    repeat (46) tick();
    Redirect = 1'b0;
    chk("sat_ff", 32'(BubbleCnt), 32'hFF);
    tick(); chkValid("sat_tgt", 12'h100);
    chk("sat_hold", 32'(BubbleCnt), 32'hFF);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
